// File: rtl/decode_pkg.sv
// Shared opcodes, control-field layout and decode helpers for the MIPS decode stage.
package decode_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned WB_W       = 2;
    localparam int unsigned M_W        = 3;
    localparam int unsigned ALUOP_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;

    localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT  = 2'b10;

    // Bit positions inside the WB and M control groups
    localparam int unsigned WB_REG_WRITE  = 1;
    localparam int unsigned WB_MEM_TO_REG = 0;
    localparam int unsigned M_BRANCH      = 2;
    localparam int unsigned M_MEM_READ    = 1;
    localparam int unsigned M_MEM_WRITE   = 0;

    typedef struct packed {
        logic [WB_W-1:0]    wb;
        logic [M_W-1:0]     m;
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctl_t;

    localparam ctl_t CTL_NOP = '0;

    // Main control table; unknown opcodes fall through as a NOP
    function automatic ctl_t decode_ctl(input logic [OPCODE_W-1:0] opcode);
        ctl_t c;
        c = CTL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst          = 1'b1;
                c.alu_op           = ALUOP_FUNCT;
                c.wb[WB_REG_WRITE] = 1'b1;
            end
            OP_LW: begin
                c.alu_src           = 1'b1;
                c.alu_op            = ALUOP_MEM;
                c.m[M_MEM_READ]     = 1'b1;
                c.wb[WB_REG_WRITE]  = 1'b1;
                c.wb[WB_MEM_TO_REG] = 1'b1;
            end
            OP_SW: begin
                c.alu_src        = 1'b1;
                c.alu_op         = ALUOP_MEM;
                c.m[M_MEM_WRITE] = 1'b1;
            end
            OP_BEQ: begin
                c.alu_op      = ALUOP_BRANCH;
                c.m[M_BRANCH] = 1'b1;
            end
            default: c = CTL_NOP;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination
    function automatic logic reads_rt(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: compares the load in ID/EX against the sources of IF/ID.
module hazard_unit
    import decode_pkg::*;
#(
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [OPCODE_W-1:0]   if_id_opcode,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  stall_c
);

    logic rs_hit_c;
    logic rt_hit_c;

    always_comb begin
        rs_hit_c = (id_ex_rt == if_id_rs);
        rt_hit_c = (id_ex_rt == if_id_rt) && reads_rt(if_id_opcode);
        stall_c  = HAZARD_EN && id_ex_mem_read && (id_ex_rt != '0) && (rs_hit_c || rt_hit_c);
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: control decode, register file with WB bypass, immediate
// extension, load-use stall and the ID/EX pipeline register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          HAZARD_EN = 1'b1,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    IF_ID_instruction,
    input  logic [DATA_W-1:0]     IF_ID_npc,
    input  logic [REG_ADDR_W-1:0] MEM_WB_rd,
    input  logic                  MEM_WB_reg_write,
    input  logic [DATA_W-1:0]     WB_mux5_write_data,
    input  logic                  flush,
    output logic                  stall,
    output logic [WB_W-1:0]       wb_ctl_out,
    output logic [M_W-1:0]        m_ctl_out,
    output logic                  reg_dst,
    output logic                  alu_src,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]     npc_out,
    output logic [DATA_W-1:0]     r_data1_out,
    output logic [DATA_W-1:0]     r_data2_out,
    output logic [DATA_W-1:0]     sign_extend_out,
    output logic [REG_ADDR_W-1:0] instruction_out_2016,
    output logic [REG_ADDR_W-1:0] instruction_out_1511
);

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_active_c;
    logic [DATA_W-1:0]     rs_data_c;
    logic [DATA_W-1:0]     rt_data_c;
    logic [DATA_W-1:0]     imm_ext_c;
    logic                  hz_stall_c;
    ctl_t                  dec_ctl_c;
    ctl_t                  ex_ctl_c;

    assign opcode = IF_ID_instruction[31:26];
    assign rs     = IF_ID_instruction[25:21];
    assign rt     = IF_ID_instruction[20:16];
    assign rd     = IF_ID_instruction[15:11];

    assign wb_active_c = MEM_WB_reg_write && (MEM_WB_rd != '0);

    // Register file: reset clears every entry, r0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[REG_ADDR_W'(i)] <= '0;
            end
        end else if (wb_active_c) begin
            regs[MEM_WB_rd] <= WB_mux5_write_data;
        end
    end

    // Combinational read ports with optional same-cycle write-through
    always_comb begin
        rs_data_c = regs[rs];
        rt_data_c = regs[rt];
        if (BYPASS_EN && wb_active_c && (MEM_WB_rd == rs)) begin
            rs_data_c = WB_mux5_write_data;
        end
        if (BYPASS_EN && wb_active_c && (MEM_WB_rd == rt)) begin
            rt_data_c = WB_mux5_write_data;
        end
        if (rs == '0) begin
            rs_data_c = '0;
        end
        if (rt == '0) begin
            rt_data_c = '0;
        end
    end

    assign imm_ext_c = DATA_W'($signed(IF_ID_instruction[IMM_W-1:0]));

    hazard_unit #(
        .HAZARD_EN (HAZARD_EN)
    ) u_hazard (
        .id_ex_mem_read (m_ctl_out[M_MEM_READ]),
        .id_ex_rt       (instruction_out_2016),
        .if_id_opcode   (opcode),
        .if_id_rs       (rs),
        .if_id_rt       (rt),
        .stall_c        (hz_stall_c)
    );

    // ID/EX state is undefined during reset, so the stall is masked there
    assign stall = hz_stall_c && !rst;

    // Flush and stall both turn the entering instruction into a bubble
    always_comb begin
        dec_ctl_c = decode_ctl(opcode);
        ex_ctl_c  = dec_ctl_c;
        if (flush || stall) begin
            ex_ctl_c = CTL_NOP;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctl_out           <= '0;
            m_ctl_out            <= '0;
            reg_dst              <= 1'b0;
            alu_src              <= 1'b0;
            alu_op               <= '0;
            npc_out              <= '0;
            r_data1_out          <= '0;
            r_data2_out          <= '0;
            sign_extend_out      <= '0;
            instruction_out_2016 <= '0;
            instruction_out_1511 <= '0;
        end else begin
            wb_ctl_out           <= ex_ctl_c.wb;
            m_ctl_out            <= ex_ctl_c.m;
            reg_dst              <= ex_ctl_c.reg_dst;
            alu_src              <= ex_ctl_c.alu_src;
            alu_op               <= ex_ctl_c.alu_op;
            npc_out              <= IF_ID_npc;
            r_data1_out          <= rs_data_c;
            r_data2_out          <= rt_data_c;
            sign_extend_out      <= imm_ext_c;
            instruction_out_2016 <= rt;
            instruction_out_1511 <= rd;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a bypassing instance and a non-bypassing one share stimulus.
module tb_decode_stage;

    localparam int unsigned DW = 32;

    localparam logic [8:0] C_NOP = 9'b00_000_0_0_00;
    localparam logic [8:0] C_R   = 9'b10_000_1_0_10;
    localparam logic [8:0] C_LW  = 9'b11_010_0_1_00;
    localparam logic [8:0] C_SW  = 9'b00_001_0_1_00;
    localparam logic [8:0] C_BEQ = 9'b00_100_0_0_01;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr;
    logic [DW-1:0] npc;
    logic [4:0]    wb_rd;
    logic          wb_en;
    logic [DW-1:0] wb_data;
    logic          flush;

    logic          stall, stall_nb;
    logic [1:0]    wb_ctl, wb_ctl_nb;
    logic [2:0]    m_ctl, m_ctl_nb;
    logic          reg_dst, reg_dst_nb, alu_src, alu_src_nb;
    logic [1:0]    alu_op, alu_op_nb;
    logic [DW-1:0] npc_o, npc_o_nb, rd1, rd1_nb, rd2, rd2_nb, se, se_nb;
    logic [4:0]    rt_o, rt_o_nb, rd_o, rd_o_nb;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(DW), .HAZARD_EN(1'b1), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .IF_ID_instruction(instr), .IF_ID_npc(npc),
        .MEM_WB_rd(wb_rd), .MEM_WB_reg_write(wb_en), .WB_mux5_write_data(wb_data),
        .flush(flush), .stall(stall), .wb_ctl_out(wb_ctl), .m_ctl_out(m_ctl),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .npc_out(npc_o),
        .r_data1_out(rd1), .r_data2_out(rd2), .sign_extend_out(se),
        .instruction_out_2016(rt_o), .instruction_out_1511(rd_o)
    );

    decode_stage #(.DATA_W(DW), .HAZARD_EN(1'b1), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .IF_ID_instruction(instr), .IF_ID_npc(npc),
        .MEM_WB_rd(wb_rd), .MEM_WB_reg_write(wb_en), .WB_mux5_write_data(wb_data),
        .flush(flush), .stall(stall_nb), .wb_ctl_out(wb_ctl_nb), .m_ctl_out(m_ctl_nb),
        .reg_dst(reg_dst_nb), .alu_src(alu_src_nb), .alu_op(alu_op_nb), .npc_out(npc_o_nb),
        .r_data1_out(rd1_nb), .r_data2_out(rd2_nb), .sign_extend_out(se_nb),
        .instruction_out_2016(rt_o_nb), .instruction_out_1511(rd_o_nb)
    );

    typedef struct {
        logic          stall;
        logic [8:0]    ctl;
        logic          chk_data;
        logic [DW-1:0] npc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] rd1_nb;
        logic [DW-1:0] se;
        logic [4:0]    rt;
        logic [4:0]    rd;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step_no     = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step_no, act, exp);
        end
    endtask

    // Drive one IF/ID + WB cycle and queue the stall expected now and the ID/EX contents after the edge
    task automatic step(input logic r, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [DW-1:0] wd,
                        input logic xs, input logic [8:0] xc, input logic cd,
                        input logic [DW-1:0] x1, input logic [DW-1:0] x2, input logic [DW-1:0] x1nb);
        exp_t e;
        logic [DW-1:0] pc;
        @(negedge clk);
        pc      = DW'(32'h0000_0400 + 32'(step_no) * 32'd4);
        rst     = r;
        instr   = ins;
        npc     = pc;
        flush   = fl;
        wb_en   = we;
        wb_rd   = wrd;
        wb_data = wd;
        e.stall    = xs;
        e.ctl      = r ? C_NOP : xc;
        e.chk_data = cd;
        e.npc      = r ? '0 : pc;
        e.rd1      = r ? '0 : x1;
        e.rd2      = r ? '0 : x2;
        e.rd1_nb   = r ? '0 : x1nb;
        e.se       = r ? '0 : {{(DW-16){ins[15]}}, ins[15:0]};
        e.rt       = r ? 5'd0 : ins[20:16];
        e.rd       = r ? 5'd0 : ins[15:11];
        q.push_back(e);
        step_no++;
    endtask

    // Monitor: stall before the edge, ID/EX outputs after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q[0];
                cmp("stall", 64'(stall), 64'(e.stall));
                @(posedge clk);
                #1;
                cmp("ctl", 64'({wb_ctl, m_ctl, reg_dst, alu_src, alu_op}), 64'(e.ctl));
                if (e.chk_data) begin
                    cmp("npc_out", 64'(npc_o), 64'(e.npc));
                    cmp("r_data1_out", 64'(rd1), 64'(e.rd1));
                    cmp("r_data2_out", 64'(rd2), 64'(e.rd2));
                    cmp("r_data1_out_nobypass", 64'(rd1_nb), 64'(e.rd1_nb));
                    cmp("sign_extend_out", 64'(se), 64'(e.se));
                    cmp("instruction_out_2016", 64'(rt_o), 64'(e.rt));
                    cmp("instruction_out_1511", 64'(rd_o), 64'(e.rd));
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst     = 1'b1;
        instr   = 32'h8C22_0004;
        npc     = '0;
        flush   = 1'b0;
        wb_en   = 1'b0;
        wb_rd   = 5'd0;
        wb_data = '0;

        // Reset held for two cycles with a lw in IF/ID
        step(1, 32'h8C22_0004, 0, 0, 5'd0, '0,      0, C_NOP, 1, '0, '0, '0);
        step(1, 32'h8C22_0004, 0, 0, 5'd0, '0,      0, C_NOP, 1, '0, '0, '0);
        // Read r1 right after reset
        step(0, 32'h0020_0020, 0, 0, 5'd0, '0,      0, C_R,   1, '0, '0, '0);
        // Illegal opcode while WB loads r1=5, r2=7
        step(0, 32'hFC00_0000, 0, 1, 5'd1, 32'd5,   0, C_NOP, 1, '0, '0, '0);
        step(0, 32'hFC00_0000, 0, 1, 5'd2, 32'd7,   0, C_NOP, 1, '0, '0, '0);
        // add r3,r1,r2
        step(0, 32'h0022_1820, 0, 0, 5'd0, '0,      0, C_R,   1, 32'd5, 32'd7, 32'd5);
        // Same-cycle write of r4 while reading r4
        step(0, 32'h0080_2820, 0, 1, 5'd4, 32'hDEAD, 0, C_R,  1, 32'hDEAD, '0, '0);
        // lw r2,0(r1) then dependent add r3,r2,r5: one stall, one bubble, then the add
        step(0, 32'h8C22_0000, 0, 0, 5'd0, '0,      0, C_LW,  1, 32'd5, 32'd7, 32'd5);
        step(0, 32'h0045_1820, 0, 0, 5'd0, '0,      1, C_NOP, 0, '0, '0, '0);
        step(0, 32'h0045_1820, 0, 0, 5'd0, '0,      0, C_R,   1, 32'd7, '0, 32'd7);
        // lw followed by a lw whose rt matches: no hazard; negative immediate
        step(0, 32'h8C22_0004, 0, 0, 5'd0, '0,      0, C_LW,  1, 32'd5, 32'd7, 32'd5);
        step(0, 32'h8C62_8000, 0, 0, 5'd0, '0,      0, C_LW,  1, '0, 32'd7, '0);
        // sw rt hazard together with flush, then sw decodes
        step(0, 32'hAC82_0000, 1, 0, 5'd0, '0,      1, C_NOP, 1, 32'hDEAD, 32'd7, 32'hDEAD);
        step(0, 32'hAC82_0000, 0, 0, 5'd0, '0,      0, C_SW,  1, 32'hDEAD, 32'd7, 32'hDEAD);
        // Write to r0 is ignored, both the bypass and the stored value
        step(0, 32'h0000_3020, 0, 1, 5'd0, 32'hFFFF, 0, C_R,  1, '0, '0, '0);
        step(0, 32'h0000_3020, 0, 0, 5'd0, '0,      0, C_R,   1, '0, '0, '0);
        // beq with all-ones immediate
        step(0, 32'h1022_FFFF, 0, 0, 5'd0, '0,      0, C_BEQ, 1, 32'd5, 32'd7, 32'd5);
        // Mid-stream reset masks a pending load-use hazard and clears the register file
        step(0, 32'h8C22_0000, 0, 0, 5'd0, '0,      0, C_LW,  1, 32'd5, 32'd7, 32'd5);
        step(1, 32'h0045_1820, 0, 0, 5'd0, '0,      0, C_NOP, 1, '0, '0, '0);
        step(0, 32'h0020_0020, 0, 0, 5'd0, '0,      0, C_R,   1, '0, '0, '0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised MIPS instruction-decode stage: main control, register file, immediate extension and ID/EX pipeline register in one clocked block. It adds over the previous decode stage: a load-use hazard detector with stall/bubble generation, a branch/exception flush input, register-file write-through bypass, and a configurable datapath width. It sits between the IF/ID register and the execute stage.

## Interface

Parameters:

- `DATA_W`, default 32: datapath width (register contents, NPC, extended immediate). Legal range is 16 or more.
- `HAZARD_EN`, default 1: 1 enables load-use detection; 0 forces `stall` to 0.
- `BYPASS_EN`, default 1: 1 makes a same-cycle WB write visible to the ID read.

Ports (one clock; reset is synchronous and active-high):

- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `IF_ID_instruction` input 32: instruction held in IF/ID.
- `IF_ID_npc` input DATA_W: PC+4 of that instruction.
- `MEM_WB_rd` input 5: write-back destination register.
- `MEM_WB_reg_write` input 1: write-back enable.
- `WB_mux5_write_data` input DATA_W: write-back data.
- `flush` input 1: squash the instruction entering ID/EX.
- `stall` output 1: load-use hazard. The upstream stage holds PC and IF/ID while it is high.
- `wb_ctl_out` output 2: {reg_write, mem_to_reg}.
- `m_ctl_out` output 3: {branch, mem_read, mem_write}.
- `reg_dst` output 1: EX control.
- `alu_src` output 1: EX control.
- `alu_op` output 2: EX control.
- `npc_out` output DATA_W: registered NPC.
- `r_data1_out` output DATA_W: registered rs value.
- `r_data2_out` output DATA_W: registered rt value.
- `sign_extend_out` output DATA_W: registered sign-extended `instruction[15:0]`.
- `instruction_out_2016` output 5: registered rt field.
- `instruction_out_1511` output 5: registered rd field.

## Operation

- **Control decode** from `opcode = instruction[31:26]`. Each line gives RegDst/ALUSrc/ALUOp, then Branch/MemRead/MemWrite, then RegWrite/MemToReg:
  - R-type (0x00): 1/0/10, 0/0/0, 1/0.
  - lw (0x23): 0/1/00, 0/1/0, 1/1.
  - sw (0x2B): 0/1/00, 0/0/1, 0/0.
  - beq (0x04): 0/0/01, 1/0/0, 0/0.
  - Any other opcode decodes to all-zero control (a NOP).
- **Register file**: 32 x DATA_W registers.
  - Written on the rising edge when `MEM_WB_reg_write` is 1 and `MEM_WB_rd` is not 0.
  - Register 0 always reads as 0.
  - Reads are combinational.
  - With `BYPASS_EN` = 1: if a write targets the same non-zero register being read in that cycle, the read returns `WB_mux5_write_data`.
- **Immediate**: `instruction[15]` is replicated into bits DATA_W-1 down to 16.
- **Hazard detection**: `stall` = 1 when all of the following hold:
  - `HAZARD_EN` = 1;
  - ID/EX `mem_read` (`m_ctl_out[1]`) is 1;
  - `instruction_out_2016` is not 0;
  - `instruction_out_2016` equals IF/ID rs, or it equals IF/ID rt and the IF/ID opcode is R-type, sw or beq.
- **ID/EX register update priority**, evaluated at each rising edge:
  1. `rst`: all outputs load 0. The register file also clears to 0.
  2. `flush`: control fields (wb, m, reg_dst, alu_src, alu_op) load 0. Data and field outputs load normally.
  3. `stall`: control fields load 0 (bubble). Data and fields load normally, and are don't-care.
  4. Otherwise: all fields load the decoded values.
- `stall` is combinational from IF/ID and ID/EX state. It is 0 while `rst` is 1 and in the cycle after reset.
- Write-back occurs during `flush` or `stall`; those signals never block it.

## Timing

- ID/EX latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
- Register-file write becomes visible:
  - in the same cycle when `BYPASS_EN` = 1;
  - in the following cycle when `BYPASS_EN` = 0.
- A load-use pair produces exactly one bubble. In the next cycle the lw has left ID/EX, so `stall` drops.
- `flush` and `stall` high together: one bubble is inserted, and `stall` is still reported upstream.
- `rst` asserted mid-stream clears all state in one edge and has no residual effect afterwards.

## Structure

- Package `decode_pkg`:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`;
  - ALUOp constants;
  - WB/M/EX bit-position constants.
- Sub-module `hazard_unit`: purely combinational stall logic.
- The register file, control decode and ID/EX register are inline.

## Test plan

- **Reset**: hold `rst` for 2 cycles with `IF_ID_instruction`=0x8C220004 -> all outputs 0, `stall`=0, and reading r1 afterwards returns 0.
- **R-type decode**: write r1=5 and r2=7 via WB. Apply add r3,r1,r2 (0x00221820) -> next cycle `wb_ctl_out`=10, `m_ctl_out`=000, `reg_dst`=1, `alu_op`=10, `r_data1_out`=5, `r_data2_out`=7, `instruction_out_1511`=3.
- **Bypass**: WB writes r4=0xDEAD in the same cycle ID reads r4 -> `r_data1_out`=0xDEAD. With `BYPASS_EN`=0 the old value is returned.
- **Load-use**: lw r2,0(r1) followed by add r3,r2,r5 -> `stall`=1 for exactly 1 cycle, then a bubble (all control 0), then the add decodes.
- **Register 0 and sign extension**: a WB write to r0 of 0xFFFF is ignored and r0 reads 0. Apply lw with imm 0x8000 and `DATA_W`=32 -> `sign_extend_out`=0xFFFF8000.
- **Flush and illegal opcode**: `flush`=1 with sw decoding -> controls 0 and `npc_out` still updates. Opcode 0x3F -> all control 0.
